imem_fetch_responder: RTL and testbench

- Instruction-memory responder at the far end of the fetch interface. The program counter drives byte addresses in; this block returns the instruction words.
- Word-addressed synchronous ROM/RAM with a valid/ready request channel, a 1-cycle read stage and a small response FIFO.
- Flags misaligned and out-of-range fetches. Raises a sticky halt on an out-of-range fetch, replacing the ad-hoc stop at address 32764.
- Side loader port fills the memory before and during simulation.

---
 rtl/imem_pkg.sv | 29 ++
 rtl/imem_fetch_responder_resp_fifo.sv | 70 +++++++
 rtl/imem_fetch_responder.sv | 117 +++++++++++
 tb/tb_imem_fetch_responder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory fetch responder.
package imem_pkg;

    localparam logic [1:0]  ERR_OK       = 2'b00;
    localparam logic [1:0]  ERR_MISALIGN = 2'b01;
    localparam logic [1:0]  ERR_RANGE    = 2'b10;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
    localparam int unsigned DEF_ADDR_LIMIT = 32'd32764;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
        logic [1:0]  err;
    } rsp_t;

    localparam int RSP_W = $bits(rsp_t);

    // Range violations take priority over misalignment.
    function automatic logic [1:0] classify(input logic [31:0] addr, input logic [31:0] limit);
        if (addr >= limit) begin
            return ERR_RANGE;
        end else if (addr[1:0] != 2'b00) begin
            return ERR_MISALIGN;
        end else begin
            return ERR_OK;
        end
    endfunction

endpackage

// File: rtl/imem_fetch_responder_resp_fifo.sv
// Small first-word-fall-through FIFO; output reads zero while empty.
module resp_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 67,
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_push,
    input  logic [W-1:0]  i_din,
    input  logic          i_pop,
    output logic [W-1:0]  o_dout,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign o_count = r_count;
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);

    // Head presentation, masked to zero when nothing is queued.
    always_comb begin
        o_dout = '0;
        if (o_empty) begin
            o_dout = '0;
        end else begin
            o_dout = r_mem[r_rptr];
        end
    end

    // Entry storage; contents are don't-care once popped.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_din;
        end
    end

    // Pointers wrap at DEPTH, which need not be a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == PW'(DEPTH - 1)) ? '0 : r_rptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/imem_fetch_responder.sv
// Instruction memory at the far end of the fetch path: one-cycle read stage
// feeding a response FIFO, with range/alignment flags and a sticky halt.
module imem_fetch_responder
    import imem_pkg::*;
#(
    parameter int          DEPTH      = 8192,
    parameter int unsigned ADDR_LIMIT = DEF_ADDR_LIMIT,
    parameter int          FIFO_DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [31:0]   req_addr,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_instr,
    output logic [31:0]   rsp_addr,
    output logic [1:0]    rsp_err,
    output logic          halted,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [31:0]   ld_data
);

    logic [31:0]   r_mem [DEPTH];
    logic          r_s1_valid;
    rsp_t          r_s1;
    logic          r_blocked;
    logic          r_halted;

    logic [AW-1:0] w_idx;
    logic [1:0]    w_err;
    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    logic          w_room;
    logic [CW:0]   w_occ;
    logic [CW-1:0] w_count;
    logic          w_full;
    logic          w_empty;
    logic [RSP_W-1:0] w_head_bits;
    rsp_t          w_head;

    assign w_idx   = req_addr[AW+1:2];
    assign w_err   = classify(req_addr, ADDR_LIMIT);
    assign w_head  = rsp_t'(w_head_bits);
    assign w_pop   = !w_empty && rsp_ready;
    assign w_push  = r_s1_valid && (!w_full || w_pop);
    assign w_occ   = (CW+1)'(r_s1_valid) + (CW+1)'(w_count);
    assign w_room  = (w_occ < (CW+1)'(FIFO_DEPTH));

    // Popping this cycle frees a slot, so rsp_ready feeds req_ready directly.
    assign req_ready = !r_halted && !r_blocked && (w_room || w_pop);
    assign w_accept  = req_valid && req_ready;

    assign rsp_valid = !w_empty;
    assign rsp_instr = w_head.instr;
    assign rsp_addr  = w_head.addr;
    assign rsp_err   = w_head.err;
    assign halted    = r_halted;

    // Loader write port; a same-cycle fetch of this word sees the old value.
    always_ff @(posedge clk) begin
        if (ld_we) begin
            r_mem[ld_addr] <= ld_data;
        end
    end

    // Read stage: memory word registered together with its address and flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1       <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1.instr <= (w_err == ERR_RANGE) ? NOP_INSTR : r_mem[w_idx];
                r_s1.addr  <= req_addr;
                r_s1.err   <= w_err;
            end
        end
    end

    // Out-of-range accept stops intake; halt itself waits for that response to leave.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_blocked <= 1'b0;
            r_halted  <= 1'b0;
        end else begin
            if (w_accept && (w_err == ERR_RANGE)) begin
                r_blocked <= 1'b1;
            end
            if (w_pop && (w_head.err == ERR_RANGE)) begin
                r_halted <= 1'b1;
            end
        end
    end

    resp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (RSP_W)
    ) u_rsp_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_din   (r_s1),
        .i_pop   (w_pop),
        .o_dout  (w_head_bits),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Directed bench for imem_fetch_responder: vector table plus handshake corner sequences.
module tb_imem_fetch_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic [31:0] rsp_addr;
    logic [1:0]  rsp_err;
    logic        halted;
    logic        ld_we;
    logic [12:0] ld_addr;
    logic [31:0] ld_data;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp_instr;
        logic [1:0]  exp_err;
    } vec_t;

    vec_t vecs [8];

    imem_fetch_responder dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_addr  (rsp_addr),
        .rsp_err   (rsp_err),
        .halted    (halted),
        .ld_we     (ld_we),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic load(input logic [12:0] idx, input logic [31:0] data);
        ld_we   = 1'b1;
        ld_addr = idx;
        ld_data = data;
        step();
        ld_we   = 1'b0;
    endtask

    // Single fetch with an empty pipeline: checks 2-cycle latency and payload.
    task automatic fetch(input string nm, input logic [31:0] a, input logic [31:0] ei, input logic [1:0] ee);
        int waited;
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = a;
        waited    = 0;
        while (!req_ready && waited < 20) begin
            step();
            waited++;
        end
        chk({nm, "_ready"}, {31'b0, req_ready}, 32'd1);
        step();
        req_valid = 1'b0;
        chk({nm, "_lat1"}, {31'b0, rsp_valid}, 32'd0);
        step();
        chk({nm, "_valid"}, {31'b0, rsp_valid}, 32'd1);
        chk({nm, "_instr"}, rsp_instr, ei);
        chk({nm, "_addr"}, rsp_addr, a);
        chk({nm, "_err"}, {30'b0, rsp_err}, {30'b0, ee});
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    localparam logic [31:0] M0 = 32'h2008_0005;
    localparam logic [31:0] M1 = 32'h2009_0007;
    localparam logic [31:0] M2 = 32'h0109_5020;
    localparam logic [31:0] M3 = 32'hAC0A_0000;
    localparam logic [31:0] MT = 32'hCAFE_0001;

    logic [31:0] mexp [4];

    initial begin
        mexp[0] = M0; mexp[1] = M1; mexp[2] = M2; mexp[3] = M3;
        vecs[0] = '{32'd0,     M0, 2'b00};
        vecs[1] = '{32'd4,     M1, 2'b00};
        vecs[2] = '{32'd8,     M2, 2'b00};
        vecs[3] = '{32'd12,    M3, 2'b00};
        vecs[4] = '{32'd6,     M1, 2'b01};
        vecs[5] = '{32'd1,     M0, 2'b01};
        vecs[6] = '{32'd32760, MT, 2'b00};
        vecs[7] = '{32'd32763, MT, 2'b01};

        reset = 1'b1; req_valid = 1'b0; req_addr = 32'd0; rsp_ready = 1'b0;
        ld_we = 1'b0; ld_addr = 13'd0; ld_data = 32'd0;
        // Loader works while reset is held.
        load(13'd0, M0);
        load(13'd1, M1);
        load(13'd2, M2);
        load(13'd3, M3);
        load(13'd8190, MT);
        reset = 1'b0;
        #1;
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_halted", {31'b0, halted}, 32'd0);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_instr", rsp_instr, 32'd0);
        chk("rst_addr", rsp_addr, 32'd0);
        chk("rst_err", {30'b0, rsp_err}, 32'd0);

        // Back-to-back: one response per cycle after the first edge.
        rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            if (cyc < 4) begin
                req_valid = 1'b1;
                req_addr  = 32'(4 * cyc);
                chk("b2b_ready", {31'b0, req_ready}, 32'd1);
            end else begin
                req_valid = 1'b0;
            end
            step();
            if (cyc >= 1 && cyc <= 4) begin
                chk("b2b_valid", {31'b0, rsp_valid}, 32'd1);
                chk("b2b_addr", rsp_addr, 32'(4 * (cyc - 1)));
                chk("b2b_instr", rsp_instr, mexp[cyc-1]);
                chk("b2b_err", {30'b0, rsp_err}, 32'd0);
            end else begin
                chk("b2b_idle", {31'b0, rsp_valid}, 32'd0);
            end
        end

        // Backpressure: two accepts fill the pipeline.
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_addr = 32'd0;
        chk("bp_rdy0", {31'b0, req_ready}, 32'd1);
        step();
        req_addr = 32'd4;
        chk("bp_rdy1", {31'b0, req_ready}, 32'd1);
        step();
        req_addr = 32'd8;
        chk("bp_rdy2", {31'b0, req_ready}, 32'd0);
        step();
        chk("bp_rdy3", {31'b0, req_ready}, 32'd0);
        chk("bp_hold_addr", rsp_addr, 32'd0);
        step();
        chk("bp_hold_addr2", rsp_addr, 32'd0);
        rsp_ready = 1'b1;
        #1;
        chk("bp_rdy_comb", {31'b0, req_ready}, 32'd1);
        step();
        req_valid = 1'b0;
        chk("bp_d1_addr", rsp_addr, 32'd4);
        chk("bp_d1_instr", rsp_instr, M1);
        step();
        chk("bp_d2_valid", {31'b0, rsp_valid}, 32'd1);
        chk("bp_d2_addr", rsp_addr, 32'd8);
        chk("bp_d2_instr", rsp_instr, M2);
        step();
        chk("bp_empty", {31'b0, rsp_valid}, 32'd0);
        rsp_ready = 1'b0;

        foreach (vecs[i]) begin
            fetch($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp_instr, vecs[i].exp_err);
        end
        chk("mis_halted", {31'b0, halted}, 32'd0);

        // Reset drops the queued response and the read in flight.
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_addr = 32'd4;
        step();
        req_addr = 32'd8;
        step();
        req_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mrst_valid", {31'b0, rsp_valid}, 32'd0);
        chk("mrst_halted", {31'b0, halted}, 32'd0);
        chk("mrst_ready", {31'b0, req_ready}, 32'd1);
        step();
        chk("mrst_valid2", {31'b0, rsp_valid}, 32'd0);
        fetch("mrst_fetch", 32'd0, M0, 2'b00);

        // Loader collides with a fetch of the same word.
        req_valid = 1'b1; req_addr = 32'd8;
        ld_we = 1'b1; ld_addr = 13'd2; ld_data = 32'hDEAD_BEEF;
        chk("col_ready", {31'b0, req_ready}, 32'd1);
        step();
        ld_we = 1'b0; req_valid = 1'b0;
        step();
        chk("col_old", rsp_instr, M2);
        rsp_ready = 1'b1;
        step();
        fetch("col_new", 32'd8, 32'hDEAD_BEEF, 2'b00);

        // Last legal word then first illegal address.
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_addr = 32'd32760;
        step();
        req_addr = 32'd32764;
        chk("rng_ready", {31'b0, req_ready}, 32'd1);
        step();
        chk("rng_blocked", {31'b0, req_ready}, 32'd0);
        chk("rng_a_addr", rsp_addr, 32'd32760);
        chk("rng_a_instr", rsp_instr, MT);
        chk("rng_a_err", {30'b0, rsp_err}, 32'd0);
        step();
        chk("rng_b_addr", rsp_addr, 32'd32764);
        chk("rng_b_instr", rsp_instr, 32'd0);
        chk("rng_b_err", {30'b0, rsp_err}, 32'd2);
        chk("rng_b_halted", {31'b0, halted}, 32'd0);
        step();
        chk("rng_halted", {31'b0, halted}, 32'd1);
        req_addr = 32'd0;
        for (int k = 0; k < 10; k++) begin
            chk("halt_ready", {31'b0, req_ready}, 32'd0);
            chk("halt_valid", {31'b0, rsp_valid}, 32'd0);
            step();
        end
        chk("halt_sticky", {31'b0, halted}, 32'd1);
        req_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("unhalt", {31'b0, halted}, 32'd0);
        chk("unhalt_ready", {31'b0, req_ready}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
